adc_readout_sequencer: RTL and testbench
========================================

ADC_READOUT_SEQUENCER -- requirements
Module: adc_readout_sequencer

Interface
REQ-001 Parameter pCOUNT_WIDTH, default 16, width of the sample-count input and internal counter.
REQ-002 Parameter pUNDERFLOW_BYTE, default 8'hEE, byte returned when a read arrives with no byte ready.
REQ-003 clk_usb  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 I_start  input  1  one-cycle pulse; begins a readout burst.
REQ-006 I_abort  input  1  one-cycle pulse; ends the burst immediately.
REQ-007 I_low_res  input  1  1 = 8 bits/sample, 0 = 12 bits/sample; sampled on I_start.
REQ-008 I_num_samples  input  pCOUNT_WIDTH  samples in the burst; sampled on I_start; 0 = empty burst.
REQ-009 I_fifo_empty  input  1  sample FIFO empty.
REQ-010 I_fifo_dout  input  12  sample FIFO data, valid one cycle after O_fifo_rd_en.
REQ-011 O_fifo_rd_en  output  1  sample FIFO pop.
REQ-012 I_byte_req  input  1  one-cycle pulse per USB byte read.
REQ-013 O_byte  output  8  current readout byte.
REQ-014 O_byte_valid  output  1  O_byte holds a real byte.
REQ-015 O_busy  output  1  burst in progress.
REQ-016 O_underflow  output  1  sticky; set on I_byte_req with O_byte_valid=0 while busy.

Function
REQ-017 FSM states: IDLE, FETCH_A, WAIT_A, FETCH_B, WAIT_B, EMIT; I_start is accepted only in IDLE; I_start in any other state is ignored.
REQ-018 FETCH_x asserts O_fifo_rd_en for exactly one cycle, and only when I_fifo_empty=0; otherwise the FSM stays in FETCH_x.
REQ-019 WAIT_x captures I_fifo_dout one cycle after the pop and decrements the remaining-sample counter.
REQ-020 Low-res: one sample per group; the emitted byte is sample[11:4]; the FSM skips FETCH_B/WAIT_B.
REQ-021 12-bit: two samples s0, s1 per group, emitted as three bytes: s0[11:4], {s0[3:0], s1[11:8]}, s1[7:0].
REQ-022 12-bit with an odd final sample: two bytes: s0[11:4], {s0[3:0], 4'h0}.
REQ-023 EMIT drives O_byte_valid=1; each I_byte_req advances to the next byte of the group in the following cycle.
REQ-024 After the last byte of a group, the FSM returns to FETCH_A if the counter is nonzero, else to IDLE with O_busy=0.
REQ-025 Prefetch: while the last byte of a group is presented, the next group's FETCH_A/WAIT_A may proceed, so a req every 3rd cycle sustains with FIFO non-empty.
REQ-026 Latency: with FIFO non-empty, O_byte_valid rises at most 3 cycles after I_start (low-res) or 5 cycles (12-bit).
REQ-027 I_byte_req while O_byte_valid=0: O_byte=pUNDERFLOW_BYTE; no state advance; O_underflow set if busy.
REQ-028 I_num_samples=0: O_busy pulses for one cycle; no FIFO pop; no valid byte.
REQ-029 I_abort: next cycle IDLE, O_busy=0, O_byte_valid=0, counter cleared; a sample already popped is discarded; I_abort wins over simultaneous I_byte_req or I_start.
REQ-030 O_underflow clears only on reset or on an accepted I_start.

Reset
REQ-031 On reset: state IDLE; O_fifo_rd_en=0, O_byte=8'h00, O_byte_valid=0, O_busy=0, O_underflow=0; counter and sample registers 0.
REQ-032 Reset mid-burst takes effect the next edge regardless of state; no further FIFO pops.

Configuration
REQ-033 Macro READOUT_PATTERN_EN.
REQ-034 Defined: input I_pattern_mode (1 bit) exists; when it is 1, samples come from an internal 12-bit counter instead of the FIFO. The counter resets to 0 on I_start and increments per sample (mod 4096). I_fifo_empty is ignored and O_fifo_rd_en stays 0.
REQ-035 Undefined: port and counter absent; behaviour identical to I_pattern_mode=0.

Structure
REQ-036 Shared package adc_readout_pkg holds the state enum, the byte-phase constants (BYTE0..BYTE2), and the sample width 12.
REQ-037 One sub-module, sample_packer_12to8: combinational byte select from s0, s1, phase, low_res and odd_tail.

Verification
REQ-038 Low-res, 90 samples 0x000,0x010,...: 90 bytes 00,01,02...; no underflow.
REQ-039 12-bit, 6 samples 0x001..0x006: bytes 00,10,02,00,30,04,00,50,06.
REQ-040 12-bit, 3 samples 0xABC,0x123,0xFFF: bytes AB,C1,23,FF,F0; then O_busy=0.
REQ-041 FIFO empty for 20 cycles after start with reqs: O_byte=EE, O_underflow=1, no pops; data resumes in order.
REQ-042 Abort after 4 bytes of a 12-sample 12-bit burst: next cycle O_busy=0, O_byte_valid=0; a new start then reads cleanly.
REQ-043 READOUT_PATTERN_EN, pattern mode, 12-bit, 4 samples: bytes 00,00,01,00,20,03; O_fifo_rd_en never 1.

Source files
------------

// File: rtl/adc_readout_pkg.sv
// Shared types and constants for the ADC readout sequencer: FSM states,
// prefetch tracking and the byte-phase encoding of a packed group.
package adc_readout_pkg;
   localparam int SAMPLE_W = 12;

   typedef enum logic [2:0] {
      IDLE, FETCH_A, WAIT_A, FETCH_B, WAIT_B, EMIT
   } state_t;

   typedef enum logic [1:0] {
      PF_NONE, PF_POPPED, PF_READY
   } pf_t;

   localparam logic [1:0] BYTE0 = 2'd0;
   localparam logic [1:0] BYTE1 = 2'd1;
   localparam logic [1:0] BYTE2 = 2'd2;
endpackage

// File: rtl/sample_packer_12to8.sv
// Combinational byte select: packs one or two 12-bit samples into the byte
// stream (8-bit truncation in low-res mode, 3 bytes per sample pair otherwise).
module sample_packer_12to8
   import adc_readout_pkg::*;
(
   input  logic [SAMPLE_W-1:0] s0,
   input  logic [SAMPLE_W-1:0] s1,
   input  logic [1:0]          phase,
   input  logic                low_res,
   input  logic                odd_tail,
   output logic [7:0]          byte_out
);
   always_comb begin
      byte_out = s0[11:4];
      if (!low_res) begin
         case (phase)
            BYTE1:   byte_out = odd_tail ? {s0[3:0], 4'h0} : {s0[3:0], s1[11:8]};
            BYTE2:   byte_out = s1[7:0];
            default: byte_out = s0[11:4];
         endcase
      end
   end
endmodule

// File: rtl/adc_readout_sequencer.sv
// Pops ADC samples from a FIFO and serves them as a USB byte stream.
// Optional READOUT_PATTERN_EN adds I_pattern_mode (internal counting samples).
module adc_readout_sequencer
   import adc_readout_pkg::*;
#(
   parameter int unsigned pCOUNT_WIDTH    = 16,
   parameter logic [7:0]  pUNDERFLOW_BYTE = 8'hEE
) (
   input  logic                    clk_usb,
   input  logic                    reset,
   input  logic                    I_start,
   input  logic                    I_abort,
   input  logic                    I_low_res,
   input  logic [pCOUNT_WIDTH-1:0] I_num_samples,
   input  logic                    I_fifo_empty,
   input  logic [11:0]             I_fifo_dout,
   output logic                    O_fifo_rd_en,
   input  logic                    I_byte_req,
`ifdef READOUT_PATTERN_EN
   input  logic                    I_pattern_mode,
`endif
   output logic [7:0]              O_byte,
   output logic                    O_byte_valid,
   output logic                    O_busy,
   output logic                    O_underflow
);
   state_t                  state, state_n;
   pf_t                     pf, pf_n;
   logic [1:0]              phase, phase_n;
   logic [pCOUNT_WIDTH-1:0] cnt;
   logic [SAMPLE_W-1:0]     s0, s1, sample_in;
   logic                    low_res_q, odd_tail, underflow;
   logic                    pat, src_ready, pop, cap_a, cap_b, start_ok, emit_last, pf_ok;
   logic [7:0]              packed_byte;

`ifdef READOUT_PATTERN_EN
   logic [SAMPLE_W-1:0] pat_cnt;
   assign pat       = I_pattern_mode;
   assign sample_in = pat ? pat_cnt : I_fifo_dout;

   always_ff @(posedge clk_usb) begin
      if (reset)              pat_cnt <= '0;
      else if (start_ok)      pat_cnt <= '0;
      else if (cap_a || cap_b) pat_cnt <= pat_cnt + 12'd1;
   end
`else
   assign pat       = 1'b0;
   assign sample_in = I_fifo_dout;
`endif

   assign src_ready = pat || !I_fifo_empty;
   assign start_ok  = (state == IDLE) && I_start && !I_abort;
   // Phase BYTE2 is always the last byte, even if odd_tail flips under a prefetch.
   assign emit_last = low_res_q || (phase == BYTE2) || (odd_tail && phase == BYTE1);
   // s0 is free while s1[7:0] is shown, so the next group's first sample can land early.
   assign pf_ok     = (state == EMIT) && !low_res_q && (phase == BYTE2) &&
                      (cnt != '0) && (pf == PF_NONE);

   always_comb begin
      state_n = state;
      pf_n    = pf;
      phase_n = phase;
      pop     = 1'b0;
      cap_a   = 1'b0;
      cap_b   = 1'b0;
      case (state)
         IDLE: if (I_start) state_n = FETCH_A;
         FETCH_A: begin
            if (cnt == '0) state_n = IDLE;
            else if (src_ready) begin
               pop     = 1'b1;
               state_n = WAIT_A;
            end
         end
         WAIT_A: begin
            cap_a   = 1'b1;
            phase_n = BYTE0;
            state_n = (low_res_q || cnt == pCOUNT_WIDTH'(1)) ? EMIT : FETCH_B;
         end
         FETCH_B: begin
            if (src_ready) begin
               pop     = 1'b1;
               state_n = WAIT_B;
            end
         end
         WAIT_B: begin
            cap_b   = 1'b1;
            phase_n = BYTE0;
            state_n = EMIT;
         end
         EMIT: begin
            if (pf_ok && src_ready) begin
               pop  = 1'b1;
               pf_n = PF_POPPED;
            end
            if (pf == PF_POPPED) begin
               cap_a = 1'b1;
               pf_n  = PF_READY;
            end
            if (I_byte_req) begin
               if (!emit_last) phase_n = phase + 2'd1;
               else begin
                  pf_n    = PF_NONE;
                  phase_n = BYTE0;
                  if (pf == PF_READY)       state_n = (cnt == '0) ? EMIT : FETCH_B;
                  else if (pf == PF_POPPED) state_n = (cnt == pCOUNT_WIDTH'(1)) ? EMIT : FETCH_B;
                  else if (pop)             state_n = WAIT_A;
                  else                      state_n = (cnt != '0) ? FETCH_A : IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (I_abort) begin
         state_n = IDLE;
         pf_n    = PF_NONE;
         pop     = 1'b0;
         cap_a   = 1'b0;
         cap_b   = 1'b0;
      end
   end

   always_ff @(posedge clk_usb) begin
      if (reset) begin
         state     <= IDLE;
         pf        <= PF_NONE;
         phase     <= BYTE0;
         cnt       <= '0;
         s0        <= '0;
         s1        <= '0;
         low_res_q <= 1'b0;
         odd_tail  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         state <= state_n;
         pf    <= pf_n;
         phase <= phase_n;
         if (start_ok) begin
            cnt       <= I_num_samples;
            low_res_q <= I_low_res;
            odd_tail  <= 1'b0;
            underflow <= 1'b0;
         end
         if (I_abort) cnt <= '0;
         if (cap_a) begin
            s0       <= sample_in;
            cnt      <= cnt - pCOUNT_WIDTH'(1);
            odd_tail <= !low_res_q && (cnt == pCOUNT_WIDTH'(1));
         end
         if (cap_b) begin
            s1  <= sample_in;
            cnt <= cnt - pCOUNT_WIDTH'(1);
         end
         if (I_byte_req && !O_byte_valid && O_busy && !I_abort) underflow <= 1'b1;
      end
   end

   sample_packer_12to8 u_packer (
      .s0       (s0),
      .s1       (s1),
      .phase    (phase),
      .low_res  (low_res_q),
      .odd_tail (odd_tail),
      .byte_out (packed_byte)
   );

   assign O_fifo_rd_en = pop && !pat && !reset;
   assign O_byte_valid = (state == EMIT);
   assign O_busy       = (state != IDLE);
   assign O_underflow  = underflow;
   assign O_byte       = O_byte_valid ? packed_byte :
                         (I_byte_req ? pUNDERFLOW_BYTE : 8'h00);
endmodule

// File: tb/tb_adc_readout_sequencer.sv
// Directed bench for adc_readout_sequencer with a small FIFO model;
// inputs change on the falling edge, outputs are checked there too.
module tb_adc_readout_sequencer;
   logic        clk_usb = 1'b0;
   logic        reset = 1'b1, I_start = 1'b0, I_abort = 1'b0, I_low_res = 1'b0;
   logic [15:0] I_num_samples = '0;
   logic        I_fifo_empty, O_fifo_rd_en, I_byte_req = 1'b0;
   logic [11:0] I_fifo_dout = '0;
   logic [7:0]  O_byte;
   logic        O_byte_valid, O_busy, O_underflow;
`ifdef READOUT_PATTERN_EN
   logic        I_pattern_mode = 1'b0;
`endif

   int checks = 0, failures = 0;
   int pops = 0, bad_pops = 0;
   logic [11:0] fifo_mem [0:255];
   logic [7:0]  wr_ptr = '0, rd_ptr = '0;
   logic        hold_empty = 1'b0, flush = 1'b0;

   always #5 clk_usb = ~clk_usb;

   adc_readout_sequencer dut (
      .clk_usb       (clk_usb),
      .reset         (reset),
      .I_start       (I_start),
      .I_abort       (I_abort),
      .I_low_res     (I_low_res),
      .I_num_samples (I_num_samples),
      .I_fifo_empty  (I_fifo_empty),
      .I_fifo_dout   (I_fifo_dout),
      .O_fifo_rd_en  (O_fifo_rd_en),
      .I_byte_req    (I_byte_req),
`ifdef READOUT_PATTERN_EN
      .I_pattern_mode(I_pattern_mode),
`endif
      .O_byte        (O_byte),
      .O_byte_valid  (O_byte_valid),
      .O_busy        (O_busy),
      .O_underflow   (O_underflow)
   );

   // FIFO model: data appears on I_fifo_dout the cycle after a pop.
   assign I_fifo_empty = hold_empty || (rd_ptr == wr_ptr);
   always @(posedge clk_usb) begin
      if (flush) rd_ptr <= wr_ptr;
      else if (O_fifo_rd_en) begin
         if (I_fifo_empty) bad_pops <= bad_pops + 1;
         I_fifo_dout <= fifo_mem[rd_ptr];
         rd_ptr      <= rd_ptr + 8'd1;
         pops        <= pops + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [11:0] v);
      fifo_mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 8'd1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      @(negedge clk_usb);
      flush = 1'b0;
   endtask

   task automatic start(input logic lr, input logic [15:0] n);
      I_start = 1'b1; I_low_res = lr; I_num_samples = n;
      @(negedge clk_usb);
      I_start = 1'b0;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!O_byte_valid && lat < 100) begin
         @(negedge clk_usb);
         lat++;
      end
      if (lat >= 100) chk("wait_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic get_byte(input string tag, input logic [7:0] exp);
      int l;
      wait_valid(l);
      chk(tag, {23'd0, O_byte_valid, O_byte}, {23'd0, 1'b1, exp});
      I_byte_req = 1'b1;
      @(negedge clk_usb);
      I_byte_req = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, p;
      logic [7:0] exp6 [9];
      logic [7:0] exp3 [5];
      exp6 = '{8'h00, 8'h10, 8'h02, 8'h00, 8'h30, 8'h04, 8'h00, 8'h50, 8'h06};
      exp3 = '{8'hAB, 8'hC1, 8'h23, 8'hFF, 8'hF0};

      repeat (3) @(negedge clk_usb);
      chk("rst_busy", O_busy, 0);
      chk("rst_valid", O_byte_valid, 0);
      chk("rst_byte", O_byte, 8'h00);
      chk("rst_rd_en", O_fifo_rd_en, 0);
      chk("rst_underflow", O_underflow, 0);
      reset = 1'b0;
      @(negedge clk_usb);

      // low-res, 90 samples: byte i = sample[11:4]
      for (int i = 0; i < 90; i++) push(12'(i * 16));
      p = pops;
      start(1'b1, 16'd90);
      wait_valid(lat);
      chk("lat_lowres", lat + 1, 3);
      for (int i = 0; i < 90; i++) get_byte("lowres_byte", 8'(i));
      chk("lowres_busy_end", O_busy, 0);
      chk("lowres_underflow", O_underflow, 0);
      chk("lowres_pops", pops - p, 90);

      // empty burst
      p = pops;
      start(1'b0, 16'd0);
      chk("zero_busy_pulse", O_busy, 1);
      chk("zero_valid", O_byte_valid, 0);
      @(negedge clk_usb);
      chk("zero_busy_end", O_busy, 0);
      chk("zero_no_pop", pops - p, 0);

      // FIFO stalled for 20 cycles while the host keeps reading
      hold_empty = 1'b1;
      push(12'h123); push(12'h456);
      p = pops;
      start(1'b0, 16'd2);
      for (int i = 0; i < 20; i++) begin
         if (i % 4 == 0) begin
            I_byte_req = 1'b1;
            #1 chk("stall_byte", O_byte, 8'hEE);
            @(negedge clk_usb);
            I_byte_req = 1'b0;
         end else @(negedge clk_usb);
      end
      chk("stall_underflow", O_underflow, 1);
      chk("stall_no_pop", pops - p, 0);
      chk("stall_busy", O_busy, 1);
      hold_empty = 1'b0;
      get_byte("stall_b0", 8'h12);
      get_byte("stall_b1", 8'h34);
      get_byte("stall_b2", 8'h56);
      chk("stall_sticky", O_underflow, 1);

      // 12-bit, 6 samples, read as data becomes valid
      for (int i = 1; i <= 6; i++) push(12'(i));
      start(1'b0, 16'd6);
      chk("start_clears_uf", O_underflow, 0);
      wait_valid(lat);
      chk("lat_12bit", lat + 1, 5);
      for (int i = 0; i < 9; i++) get_byte("b12_byte", exp6[i]);
      chk("b12_busy_end", O_busy, 0);

      // same burst with a request every third cycle, no waiting
      for (int i = 1; i <= 6; i++) push(12'(i));
      start(1'b0, 16'd6);
      wait_valid(lat);
      for (int i = 0; i < 9; i++) begin
         chk("sustain_byte", {23'd0, O_byte_valid, O_byte}, {23'd0, 1'b1, exp6[i]});
         I_byte_req = 1'b1;
         @(negedge clk_usb);
         I_byte_req = 1'b0;
         repeat (2) @(negedge clk_usb);
      end
      chk("sustain_underflow", O_underflow, 0);
      chk("sustain_busy_end", O_busy, 0);

      // abort mid-burst, simultaneous with a request
      for (int i = 1; i <= 12; i++) push(12'(i));
      start(1'b0, 16'd12);
      for (int i = 0; i < 4; i++) get_byte("abort_pre", exp6[i]);
      I_abort = 1'b1; I_byte_req = 1'b1;
      @(negedge clk_usb);
      I_abort = 1'b0; I_byte_req = 1'b0;
      chk("abort_busy", O_busy, 0);
      chk("abort_valid", O_byte_valid, 0);
      p = pops;
      repeat (3) @(negedge clk_usb);
      chk("abort_no_pop", pops - p, 0);
      do_flush();

      // odd final sample after abort
      push(12'hABC); push(12'h123); push(12'hFFF);
      start(1'b0, 16'd3);
      for (int i = 0; i < 5; i++) get_byte("odd_byte", exp3[i]);
      chk("odd_busy_end", O_busy, 0);

      // reset mid-burst
      for (int i = 1; i <= 4; i++) push(12'(i));
      start(1'b0, 16'd4);
      get_byte("rst_mid_b0", 8'h00);
      reset = 1'b1;
      @(negedge clk_usb);
      chk("rst_mid_busy", O_busy, 0);
      chk("rst_mid_valid", O_byte_valid, 0);
      chk("rst_mid_rd_en", O_fifo_rd_en, 0);
      p = pops;
      repeat (3) @(negedge clk_usb);
      chk("rst_mid_no_pop", pops - p, 0);
      reset = 1'b0;
      do_flush();

`ifdef READOUT_PATTERN_EN
      hold_empty = 1'b1;
      I_pattern_mode = 1'b1;
      p = pops;
      start(1'b0, 16'd4);
      get_byte("pat_b0", 8'h00);
      get_byte("pat_b1", 8'h00);
      get_byte("pat_b2", 8'h01);
      get_byte("pat_b3", 8'h00);
      get_byte("pat_b4", 8'h20);
      get_byte("pat_b5", 8'h03);
      chk("pat_no_pop", pops - p, 0);
      chk("pat_busy_end", O_busy, 0);
      I_pattern_mode = 1'b0;
      hold_empty = 1'b0;
`endif

      chk("pop_while_empty", bad_pops, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
